y_argmax: RTL and testbench
===========================

Name: y_argmax

Overview:
- Downstream consumer of the network's output-buffer write stream (y_buf_en/wr_en/addr/data).
- Snoops the 10 logits per image as they are written, computes the argmax class, and compares it with a label read from a label ROM.
- Accumulates a correct-prediction count and flags completion after IN_IMG_NUM images.
- Gives on-board accuracy readout without a host readback of the output buffer.

Parameters:
- DATA_WIDTH, 32, logit word width (signed two's complement)
- ADDR_WIDTH, 32, output-buffer byte address width
- NUM_CLASS, 10, logits per image
- IN_IMG_NUM, 10, images per run
- CLS_W, 4, class index width (>= clog2(NUM_CLASS))
- IMG_W, 4, image index width (>= clog2(IN_IMG_NUM))
- CNT_W, 4, correct-count width (>= clog2(IN_IMG_NUM+1))

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- start_i  in  1  single-cycle pulse; clears state and arms collection
- y_buf_wr_en  in  1  logit word valid this cycle
- y_buf_addr  in  ADDR_WIDTH  byte address of the logit word
- y_buf_data  in  DATA_WIDTH  signed logit
- label_rd_en  out  1  label ROM read strobe
- label_rd_addr  out  IMG_W  image index to read
- label_data_i  in  CLS_W  label; valid exactly 1 cycle after label_rd_en
- pred_valid_o  out  1  one-cycle pulse per finished image
- pred_class_o  out  CLS_W  argmax class of the finished image
- pred_img_o  out  IMG_W  index of the finished image
- pred_correct_o  out  1  pred_class_o == label, qualified by pred_valid_o
- correct_cnt_o  out  CNT_W  running count of correct predictions
- all_done_o  out  1  level; high after the last image's result
- err_o  out  1  sticky; address-sequence violation

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0.
- FSM states:
  - IDLE: wr_en ignored, no error raised. start_i -> RUN.
  - RUN: collecting. After the result of image IN_IMG_NUM-1 -> DONE.
  - DONE: all_done_o=1; wr_en ignored. start_i -> RUN.
- start_i in any state: clears img/cls counters, running max, correct_cnt_o, err_o, all_done_o, and the label pipeline; enters RUN the next cycle.
- Expected address = (img_cnt*NUM_CLASS + cls_cnt)*4. Computed with a registered running byte pointer (+4 per accepted word), no multiplier.
- Accepted word: wr_en=1 in RUN and y_buf_addr == expected address.
  - cls_cnt==0: max <= data, max_idx <= 0.
  - Otherwise: if signed data > max, then max <= data, max_idx <= cls_cnt.
  - Ties keep the lower index (strict greater-than).
  - cls_cnt increments.
- Mismatched address in RUN: err_o <= 1 (sticky); word discarded; counters unchanged.
- Word NUM_CLASS-1 accepted (cycle T):
  - The final class is resolved combinationally from that word and the running max.
  - Final class is registered into hold_cls and hold_img at T+1.
  - cls_cnt <= 0; img_cnt increments.
- Label pipeline:
  - T+1: label_rd_en=1, label_rd_addr=hold_img.
  - T+2: label valid. pred_valid_o=1, pred_class_o=hold_cls, pred_img_o=hold_img, pred_correct_o=(label_data_i==hold_cls).
  - T+2: correct_cnt_o increments if correct, registered so the new value is visible at T+3.
  - Latency: last logit to pred_valid_o is 2 cycles.
- Pipeline overlap: the next image's words may arrive from T+1 onward and are accepted. The pipeline needs only 2 cycles against a 10-cycle minimum per image, so no stall or backpressure exists.
- pred_class_o and pred_img_o hold their values between pulses.
- The pred_valid_o of image IN_IMG_NUM-1 sets all_done_o on the same edge as the transition to DONE (all_done_o visible at T+3).
- correct_cnt_o saturates at IN_IMG_NUM; it cannot exceed it by construction.
- Reset asserted mid-image: everything returns to reset values immediately; the in-flight label read is dropped.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE/RUN/DONE)
  - NUM_CLASS, IN_IMG_NUM
  - BYTES_PER_WORD=4
  - Derived widths CLS_W, IMG_W, CNT_W
- One natural sub-module, argmax_tracker:
  - Holds the running max and max_idx.
  - Inputs: first-word flag, word valid, data, class index.
  - Outputs: next max_idx and final class.
- The top keeps address checking, counters, the label pipeline and the FSM.

Test Plan:
- Image 0 logits [5,-3,9,2,9,0,1,-8,4,7], label 2, back-to-back writes at addr 0..36 -> pred_class_o=2 (tie with class 4 resolves to lower index), pred_correct_o=1, pred_valid_o 2 cycles after the addr-36 write, correct_cnt_o=1.
- All logits negative [-10..-1] ascending, label 3 -> pred_class_o=9, pred_correct_o=0, correct_cnt_o unchanged.
- 10 images written back-to-back with no gaps, labels matching on 7 of them -> 10 pred_valid_o pulses with pred_img_o 0..9, correct_cnt_o=7, all_done_o high the cycle after the last pulse.
- Out-of-order write: addr 8 sent where 4 is expected -> err_o=1 sticky, word ignored; correct addr 4 then accepted and the result stays correct.
- Writes before start_i or in DONE -> ignored; err_o stays 0 and the counters do not move.
- rstn_i asserted mid-image 3, then start_i and a full 10-image run -> all outputs 0 during reset; a fresh run starts from addr 0 with correct_cnt_o counted from 0.

Source files
------------

// File: rtl/y_argmax_pkg.sv
// Shared constants and FSM encoding for the on-board argmax / accuracy checker.
package y_argmax_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NUM_CLASS      = 10;
  localparam int IN_IMG_NUM     = 10;
  localparam int BYTES_PER_WORD = 4;
  localparam int CLS_W          = $clog2(NUM_CLASS);
  localparam int IMG_W          = $clog2(IN_IMG_NUM);
  localparam int CNT_W          = $clog2(IN_IMG_NUM + 1);

endpackage

// File: rtl/y_argmax_tracker.sv
// Running signed maximum over one image's logits; ties keep the lower class index.
module y_argmax_tracker #(
  parameter int DATA_WIDTH = 32,
  parameter int CLS_W      = 4
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         clr_i,
  input  logic                         first_i,
  input  logic                         valid_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic        [CLS_W-1:0]      idx_i,
  output logic        [CLS_W-1:0]      final_cls_o
);

  logic signed [DATA_WIDTH-1:0] max_q, max_d;
  logic        [CLS_W-1:0]      idx_q, idx_d;
  logic                         take;

  always_comb begin
    take  = first_i || (data_i > max_q);
    max_d = max_q;
    idx_d = idx_q;
    if (clr_i) begin
      max_d = '0;
      idx_d = '0;
    end else if (valid_i && take) begin
      max_d = data_i;
      idx_d = idx_i;
    end
    // Index the max would hold if this word were accepted; valid on the last word.
    final_cls_o = take ? idx_i : idx_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      max_q <= '0;
      idx_q <= '0;
    end else begin
      max_q <= max_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/y_argmax.sv
// Snoops the output-buffer write stream, resolves each image's argmax class,
// checks it against a label ROM and keeps a running correct-prediction count.
module y_argmax
  import y_argmax_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_CLASS  = y_argmax_pkg::NUM_CLASS,
  parameter int IN_IMG_NUM = y_argmax_pkg::IN_IMG_NUM,
  parameter int CLS_W      = y_argmax_pkg::CLS_W,
  parameter int IMG_W      = y_argmax_pkg::IMG_W,
  parameter int CNT_W      = y_argmax_pkg::CNT_W
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         start_i,
  input  logic                         y_buf_wr_en,
  input  logic        [ADDR_WIDTH-1:0] y_buf_addr,
  input  logic signed [DATA_WIDTH-1:0] y_buf_data,
  output logic                         label_rd_en,
  output logic        [IMG_W-1:0]      label_rd_addr,
  input  logic        [CLS_W-1:0]      label_data_i,
  output logic                         pred_valid_o,
  output logic        [CLS_W-1:0]      pred_class_o,
  output logic        [IMG_W-1:0]      pred_img_o,
  output logic                         pred_correct_o,
  output logic        [CNT_W-1:0]      correct_cnt_o,
  output logic                         all_done_o,
  output logic                         err_o,
  output state_e                       state_o
);

  // Write stream is a one-way snoop: y_buf_wr_en qualifies addr/data for one
  // cycle and there is no ready; the label ROM answers exactly one cycle after
  // label_rd_en.

  state_e                  state_q, state_d;
  logic [CLS_W-1:0]        cls_cnt_q, cls_cnt_d;
  logic [IMG_W-1:0]        img_cnt_q, img_cnt_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    err_q, err_d;
  logic [CLS_W-1:0]        hold_cls_q, hold_cls_d;
  logic [IMG_W-1:0]        hold_img_q, hold_img_d;
  logic                    lbl_req_q, lbl_req_d;
  logic                    pred_pend_q, pred_pend_d;
  logic [CLS_W-1:0]        pred_cls_q, pred_cls_d;
  logic [IMG_W-1:0]        pred_img_q, pred_img_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    snoop, accept, first_word, last_word, pred_hit, last_pred;
  logic [CLS_W-1:0]        final_cls;

  always_comb begin
    snoop      = (state_q == ST_RUN) && !start_i && y_buf_wr_en &&
                 (img_cnt_q < IMG_W'(IN_IMG_NUM));
    accept     = snoop && (y_buf_addr == ptr_q);
    first_word = (cls_cnt_q == '0);
    last_word  = accept && (cls_cnt_q == CLS_W'(NUM_CLASS - 1));
    pred_hit   = pred_pend_q && (label_data_i == pred_cls_q);
    last_pred  = pred_pend_q && (pred_img_q == IMG_W'(IN_IMG_NUM - 1));
  end

  y_argmax_tracker #(
    .DATA_WIDTH (DATA_WIDTH),
    .CLS_W      (CLS_W)
  ) u_tracker (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .clr_i       (start_i),
    .first_i     (first_word),
    .valid_i     (accept),
    .data_i      (y_buf_data),
    .idx_i       (cls_cnt_q),
    .final_cls_o (final_cls)
  );

  always_comb begin
    state_d     = state_q;
    cls_cnt_d   = cls_cnt_q;
    img_cnt_d   = img_cnt_q;
    ptr_d       = ptr_q;
    err_d       = err_q;
    hold_cls_d  = hold_cls_q;
    hold_img_d  = hold_img_q;
    lbl_req_d   = last_word;
    pred_pend_d = lbl_req_q;
    pred_cls_d  = pred_cls_q;
    pred_img_d  = pred_img_q;
    cnt_d       = cnt_q;

    if (lbl_req_q) begin
      pred_cls_d = hold_cls_q;
      pred_img_d = hold_img_q;
    end

    if (pred_hit && (cnt_q < CNT_W'(IN_IMG_NUM))) begin
      cnt_d = cnt_q + 1'b1;
    end

    // The byte pointer replaces (img*NUM_CLASS + cls)*4.
    if (accept) begin
      ptr_d = ptr_q + ADDR_WIDTH'(BYTES_PER_WORD);
      if (last_word) begin
        cls_cnt_d  = '0;
        img_cnt_d  = img_cnt_q + 1'b1;
        hold_cls_d = final_cls;
        hold_img_d = img_cnt_q;
      end else begin
        cls_cnt_d = cls_cnt_q + 1'b1;
      end
    end

    if (snoop && !accept) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_RUN:  if (last_pred) state_d = ST_DONE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    if (start_i) begin
      state_d     = ST_RUN;
      cls_cnt_d   = '0;
      img_cnt_d   = '0;
      ptr_d       = '0;
      err_d       = 1'b0;
      lbl_req_d   = 1'b0;
      pred_pend_d = 1'b0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      cls_cnt_q   <= '0;
      img_cnt_q   <= '0;
      ptr_q       <= '0;
      err_q       <= 1'b0;
      hold_cls_q  <= '0;
      hold_img_q  <= '0;
      lbl_req_q   <= 1'b0;
      pred_pend_q <= 1'b0;
      pred_cls_q  <= '0;
      pred_img_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cls_cnt_q   <= cls_cnt_d;
      img_cnt_q   <= img_cnt_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
      hold_cls_q  <= hold_cls_d;
      hold_img_q  <= hold_img_d;
      lbl_req_q   <= lbl_req_d;
      pred_pend_q <= pred_pend_d;
      pred_cls_q  <= pred_cls_d;
      pred_img_q  <= pred_img_d;
      cnt_q       <= cnt_d;
    end
  end

  assign label_rd_en    = lbl_req_q;
  assign label_rd_addr  = hold_img_q;
  assign pred_valid_o   = pred_pend_q;
  assign pred_class_o   = pred_cls_q;
  assign pred_img_o     = pred_img_q;
  assign pred_correct_o = pred_hit;
  assign correct_cnt_o  = cnt_q;
  assign all_done_o     = (state_q == ST_DONE);
  assign err_o          = err_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_y_argmax.sv
// Randomized bench for y_argmax: per-image argmax model, label ROM and a per-cycle scoreboard.
module tb_y_argmax;
  import y_argmax_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NC = 10;
  localparam int NI = 10;
  localparam int CW = 4;
  localparam int IW = 4;
  localparam int KW = 4;
  localparam int NW = 4;

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 rstn_i = 1'b0;
  logic                 start_i = 1'b0;
  logic                 y_buf_wr_en = 1'b0;
  logic        [AW-1:0] y_buf_addr = '0;
  logic signed [DW-1:0] y_buf_data = '0;
  logic                 label_rd_en;
  logic        [IW-1:0] label_rd_addr;
  logic        [CW-1:0] label_data_i = '0;
  logic                 pred_valid_o;
  logic        [CW-1:0] pred_class_o;
  logic        [IW-1:0] pred_img_o;
  logic                 pred_correct_o;
  logic        [KW-1:0] correct_cnt_o;
  logic                 all_done_o;
  logic                 err_o;
  state_e               state_o;

  always #5 clk = ~clk;

  y_argmax dut (
    .clk_i          (clk),
    .rstn_i         (rstn_i),
    .start_i        (start_i),
    .y_buf_wr_en    (y_buf_wr_en),
    .y_buf_addr     (y_buf_addr),
    .y_buf_data     (y_buf_data),
    .label_rd_en    (label_rd_en),
    .label_rd_addr  (label_rd_addr),
    .label_data_i   (label_data_i),
    .pred_valid_o   (pred_valid_o),
    .pred_class_o   (pred_class_o),
    .pred_img_o     (pred_img_o),
    .pred_correct_o (pred_correct_o),
    .correct_cnt_o  (correct_cnt_o),
    .all_done_o     (all_done_o),
    .err_o          (err_o),
    .state_o        (state_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Label ROM: one-cycle read latency, garbage when not read.
  logic [CW-1:0] labels [16];
  always @(posedge clk)
    label_data_i <= label_rd_en ? labels[label_rd_addr] : CW'($urandom_range(0, 15));

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [CW-1:0] cls;
    logic [IW-1:0] img;
    logic          ok;
    logic [31:0]   cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   err_exp = 0;
  logic signed [DW-1:0] lg [NI][NC];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: strict greater-than scan, so ties stay on the lowest index.
  function automatic int argmax_of(input int img);
    int best = 0;
    for (int i = 1; i < NC; i++)
      if (lg[img][i] > lg[img][best]) best = i;
    return best;
  endfunction

  // ---------------- compare process ----------------
  initial begin
    int   cnt_model = 0;
    bit   done_model = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rstn_i) begin
        chk("reset_outputs", {pred_valid_o, pred_correct_o, all_done_o, err_o, label_rd_en,
                              pred_class_o, pred_img_o, correct_cnt_o, label_rd_addr}, 0);
        exp_q.delete();
        cnt_model  = 0;
        done_model = 0;
      end else begin
        chk("correct_cnt", correct_cnt_o, cnt_model);
        chk("all_done", all_done_o, done_model);
        if (pred_valid_o) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pred", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("pred_class", pred_class_o, e.cls);
            chk("pred_img", pred_img_o, e.img);
            chk("pred_correct", pred_correct_o, e.ok);
            chk("pred_latency", cyc, e.cyc);
            if (e.ok && cnt_model < NI) cnt_model++;
            if (e.img == IW'(NI - 1)) done_model = 1;
          end
        end
        if (start_i) begin
          exp_q.delete();
          cnt_model  = 0;
          done_model = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic quiet(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      start_i     = 1'b0;
      y_buf_wr_en = 1'b0;
    end
  endtask

  task automatic put(input int a, input logic signed [DW-1:0] d);
    @(posedge clk); #1;
    start_i     = 1'b0;
    y_buf_wr_en = 1'b1;
    y_buf_addr  = AW'(a);
    y_buf_data  = d;
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start_i     = 1'b1;
    y_buf_wr_en = 1'b0;
    err_exp     = 0;
  endtask

  task automatic send_image(input int img, input bit gaps, input int bad_at);
    exp_t e;
    for (int c = 0; c < NC; c++) begin
      if (gaps && $urandom_range(0, 3) == 0) quiet(1);
      if (c == bad_at) begin
        put((img * NC + c + 1) * NW, 32'sh7fffffff);
        err_exp = 1;
      end
      put((img * NC + c) * NW, lg[img][c]);
    end
    e.cls = CW'(argmax_of(img));
    e.img = IW'(img);
    e.ok  = (labels[img] == e.cls);
    e.cyc = 32'(cyc + 2);
    exp_q.push_back(e);
  endtask

  task automatic wait_pred(input string nm);
    int n = 0;
    while (!pred_valid_o && n < 8) begin
      quiet(1);
      n++;
    end
    chk(nm, pred_valid_o, 1);
  endtask

  task automatic gen_logits(input int img);
    int v;
    for (int c = 0; c < NC; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        lg[img][c] = $urandom;
      end else begin
        v = $urandom_range(0, 8) - 4;
        lg[img][c] = v;
      end
    end
  endtask

  task automatic run_all(input bit gaps, input int bad_img);
    do_start();
    for (int i = 0; i < NI; i++) send_image(i, gaps, (i == bad_img) ? 1 : -1);
    quiet(4);
    chk("run_all_done", all_done_o, 1);
    chk("run_err", err_o, err_exp);
    chk("run_pending", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    int n_ok;
    int am;
    logic signed [DW-1:0] img0 [NC];
    img0 = '{32'sd5, -32'sd3, 32'sd9, 32'sd2, 32'sd9, 32'sd0, 32'sd1, -32'sd8, 32'sd4, 32'sd7};
    for (int i = 0; i < 16; i++) labels[i] = '0;

    quiet(3);
    rstn_i = 1'b1;
    quiet(2);
    chk("rst_cnt", correct_cnt_o, 0);
    chk("rst_done", all_done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_state", state_o, ST_IDLE);

    // Writes while idle are ignored.
    put(0, 32'sd100);
    put(4, 32'sd5);
    put(12, 32'sd7);
    quiet(3);
    chk("idle_err", err_o, 0);
    chk("idle_state", state_o, ST_IDLE);

    // Run 1: hand-computed images, then an out-of-order write, then random.
    for (int c = 0; c < NC; c++) lg[0][c] = img0[c];
    labels[0] = 4'd2;
    for (int c = 0; c < NC; c++) lg[1][c] = DW'(c - 10);
    labels[1] = 4'd3;
    chk("model_pin_tie", argmax_of(0), 2);
    chk("model_pin_neg", argmax_of(1), 9);
    for (int i = 2; i < NI; i++) begin
      gen_logits(i);
      labels[i] = CW'($urandom_range(0, NC - 1));
    end

    do_start();
    send_image(0, 0, -1);
    c0 = cyc;
    wait_pred("img0_pulse");
    chk("img0_latency", cyc - c0, 2);
    chk("img0_class", pred_class_o, 2);
    chk("img0_correct", pred_correct_o, 1);
    quiet(1);
    chk("img0_cnt", correct_cnt_o, 1);

    send_image(1, 0, -1);
    wait_pred("img1_pulse");
    chk("img1_class", pred_class_o, 9);
    chk("img1_correct", pred_correct_o, 0);
    quiet(1);
    chk("img1_cnt", correct_cnt_o, 1);

    send_image(2, 0, 1);
    quiet(1);
    chk("err_set", err_o, 1);
    for (int i = 3; i < NI; i++) send_image(i, 1, -1);
    quiet(4);
    chk("run1_done", all_done_o, 1);
    chk("err_sticky", err_o, 1);
    chk("run1_pending", exp_q.size(), 0);

    // Run 2: back-to-back, exactly 7 labels match.
    for (int i = 0; i < NI; i++) begin
      gen_logits(i);
      am = argmax_of(i);
      labels[i] = (i == 3 || i == 6 || i == 8) ? CW'((am + 1) % NC) : CW'(am);
    end
    run_all(0, -1);
    chk("run2_cnt", correct_cnt_o, 7);
    chk("run2_state", state_o, ST_DONE);

    // Writes in DONE are ignored.
    put(NI * NC * NW, 32'sd9);
    put(0, 32'sd9);
    put(4, 32'sd9);
    quiet(3);
    chk("done_err", err_o, 0);
    chk("done_hold", all_done_o, 1);
    chk("done_cnt", correct_cnt_o, 7);

    // Run 3: reset in the middle of image 3, then a fresh full run.
    for (int i = 0; i < NI; i++) begin
      gen_logits(i);
      labels[i] = CW'($urandom_range(0, NC - 1));
    end
    do_start();
    for (int i = 0; i < 3; i++) send_image(i, 1, -1);
    for (int c = 0; c < 4; c++) put((3 * NC + c) * NW, lg[3][c]);
    @(posedge clk); #1;
    rstn_i      = 1'b0;
    y_buf_wr_en = 1'b0;
    quiet(3);
    chk("midrst_state", state_o, ST_IDLE);
    rstn_i = 1'b1;
    quiet(2);
    chk("midrst_cnt", correct_cnt_o, 0);
    for (int i = 0; i < NI; i++) begin
      gen_logits(i);
      labels[i] = ($urandom_range(0, 1) == 1) ? CW'(argmax_of(i)) : CW'($urandom_range(0, NC - 1));
    end
    n_ok = 0;
    for (int i = 0; i < NI; i++) if (labels[i] == CW'(argmax_of(i))) n_ok++;
    run_all(1, -1);
    chk("run3_cnt", correct_cnt_o, n_ok);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
